csr_rmw_unit: RTL
=================

Name: csr_rmw_unit

Overview:
- Executes Zicsr read-modify-write instructions (CSRRW/CSRRS/CSRRC and immediate forms) on behalf of the pipeline.
- Owns the writable machine counter file: mcycle, minstret, mcountinhibit, mscratch.
- Serves the user read-only shadows (cycle, time, instret and their high halves) from the same counters.
- Sits between the execute stage and writeback, behind a valid/ready request and response handshake.

Parameters:
- XLEN, 32, data width; counters are 2*XLEN bits.
- TIME_DIV, 1, `time` increments once every TIME_DIV clocks; legal values are 1 to 255.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request
- req_funct3  in  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- req_csr_addr  in  12  CSR address
- req_rs1_data  in  XLEN  source operand for register forms
- req_rs1_field  in  5  rs1 index (register forms) or zimm (immediate forms)
- instret_inc  in  1  one instruction retired this cycle
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_rdata  out  XLEN  old CSR value
- resp_illegal  out  1  illegal-instruction condition for this request

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_illegal=0. All counters, mcountinhibit and mscratch reset to 0.
- IDLE: req_ready=1. A request is accepted when req_valid&&req_ready; the fields are latched and the FSM moves to EXEC. No other state accepts requests.
- EXEC (exactly one cycle), in order:
  - Read the old value. Address map: C00/C80 cycle lo/hi; C01/C81 time lo/hi; C02/C82 instret lo/hi; B00/B80 mcycle lo/hi; B02/B82 minstret lo/hi; 320 mcountinhibit; 340 mscratch.
  - Compute the write-back value:
    - Operand is rs1_data for funct3[2]=0; otherwise zero-extended zimm.
    - RW: new = operand.
    - RS: new = old | operand.
    - RC: new = old & ~operand.
  - A write is suppressed for RS/RC/RSI/RCI when req_rs1_field==0. RW/RWI always write.
  - Set illegal if any of the following hold; illegal requests perform no write:
    - the address is unmapped;
    - a write (not suppressed) targets an address with [11:10]==2'b11;
    - funct3 is 000 or 100.
  - Then go to RESP.
- RESP: resp_valid=1, holding rdata and illegal stable until resp_ready. On resp_valid&&resp_ready, return to IDLE; req_ready is high the next cycle.
- Latency: accept at cycle T → resp_valid from T+2. Back-to-back throughput is one request per 3 cycles when resp_ready is held high.
- Read value is sampled at the start of EXEC, i.e. the pre-write counter value of that cycle.
- mcountinhibit:
  - Only bits 0 (CY) and 2 (IR) are implemented; all other bits read 0 and ignore writes.
  - CY=1 freezes mcycle; IR=1 freezes minstret.
  - time is never inhibited.
- Counter update, every cycle (reset excluded):
  - mcycle += 1 unless CY.
  - minstret += instret_inc unless IR.
  - time += 1 when the prescaler wraps. The prescaler is an internal 8-bit counter, 0..TIME_DIV-1.
- Simultaneous CSR write and increment on the same counter: the write wins for the written half and the increment is dropped that cycle.
  - The unwritten half holds its value; no carry propagates into it.
  - Example: writing mcycle lo=FFFF_FFFF leaves hi unchanged and lo=FFFF_FFFF after EXEC.
- 64-bit wrap: all-ones +1 → 0, silently.
- Reset asserted mid-operation: FSM immediately returns to IDLE, the pending response is discarded, and no partial write occurs.

Decomposition:
- Shared package csr_pkg holds:
  - CSR address constants (cycle/time/instret lo/hi, mcycle, minstret, mcountinhibit, mscratch);
  - funct3 encodings;
  - FSM state enum;
  - mcountinhibit bit indices.
- One sub-module, csr_counter64: a 64-bit counter with enable, lo/hi write strobes, write data, and the write-over-increment priority. Instantiated three times (mcycle, minstret, time).

Test Plan:
- Reset, then idle 10 cycles; CSRRS x0 at C00 → resp_rdata=10 ±1 matching EXEC-cycle sample, illegal=0, resp_valid at T+2.
- CSRRW 340 with rs1_data=DEAD_BEEF → rdata=0. Follow with CSRRC 340, rs1_data=0000_FFFF → rdata=DEAD_BEEF; a subsequent read returns DEAD_0000.
- CSRRWI 320 zimm=5 → mcycle/minstret freeze; two reads of B00 10 cycles apart return equal values. CSRRCI 320 zimm=1 → mcycle resumes, minstret stays frozen.
- CSRRW B00 with FFFF_FFFF, then wait 1 cycle → mcycle hi increments by 1 and lo=0. CSRRW B80 while counting → lo keeps running, hi=written value.
- CSRRW C00 → illegal=1, counters undisturbed. CSRRS C00 with rs1_field=0 → illegal=0. Address 7C0 → illegal=1.
- resp_ready held low 5 cycles → resp_valid and rdata stable, req_ready=0. Assert reset during RESP → resp_valid=0 immediately and req_ready=1 after release.

Source files
------------

// File: rtl/csr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csr_pkg
// Description : Shared definitions for the CSR read-modify-write unit:
//               CSR addresses, Zicsr funct3 encodings, FSM state type and
//               mcountinhibit bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package csr_pkg;

    // User read-only shadows
    localparam logic [11:0] c_csr_cycle         = 12'hC00;
    localparam logic [11:0] c_csr_time          = 12'hC01;
    localparam logic [11:0] c_csr_instret       = 12'hC02;
    localparam logic [11:0] c_csr_cycleh        = 12'hC80;
    localparam logic [11:0] c_csr_timeh         = 12'hC81;
    localparam logic [11:0] c_csr_instreth      = 12'hC82;
    // Machine writable counters and scratch
    localparam logic [11:0] c_csr_mcycle        = 12'hB00;
    localparam logic [11:0] c_csr_minstret      = 12'hB02;
    localparam logic [11:0] c_csr_mcycleh       = 12'hB80;
    localparam logic [11:0] c_csr_minstreth     = 12'hB82;
    localparam logic [11:0] c_csr_mcountinhibit = 12'h320;
    localparam logic [11:0] c_csr_mscratch      = 12'h340;

    // funct3 encodings; bit 2 selects the immediate (zimm) operand
    localparam logic [2:0] c_f3_csrrw  = 3'b001;
    localparam logic [2:0] c_f3_csrrs  = 3'b010;
    localparam logic [2:0] c_f3_csrrc  = 3'b011;
    localparam logic [2:0] c_f3_csrrwi = 3'b101;
    localparam logic [2:0] c_f3_csrrsi = 3'b110;
    localparam logic [2:0] c_f3_csrrci = 3'b111;

    // mcountinhibit implemented bits
    localparam int unsigned c_mci_cy = 0;
    localparam int unsigned c_mci_ir = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } csr_state_e;

endpackage
`default_nettype wire

// File: rtl/csr_counter64.sv
`default_nettype none
// ============================================================================
// Module      : csr_counter64
// Description : 2*XLEN-bit counter with count enable and independent lo/hi
//               half write strobes. Any write takes priority over the
//               increment for that cycle; the unwritten half holds.
// Revision    : 1.0 - initial release
// Ports       : clk, reset (async, active-high)
//               en_i      - increment enable
//               wr_lo_i   - write low half with wdata_i
//               wr_hi_i   - write high half with wdata_i
//               wdata_i   - write data (XLEN)
//               count_o   - current counter value (2*XLEN)
// ============================================================================
module csr_counter64 #(
    parameter int XLEN = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en_i,
    input  logic                wr_lo_i,
    input  logic                wr_hi_i,
    input  logic [XLEN-1:0]     wdata_i,
    output logic [2*XLEN-1:0]   count_o
);

    localparam logic [2*XLEN-1:0] c_one = {{(2*XLEN-1){1'b0}}, 1'b1};

    logic [2*XLEN-1:0] count_q;
    logic [2*XLEN-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (wr_lo_i || wr_hi_i) begin
            // Increment is dropped entirely so no carry reaches the other half
            if (wr_lo_i) count_d[XLEN-1:0]      = wdata_i;
            if (wr_hi_i) count_d[2*XLEN-1:XLEN] = wdata_i;
        end else if (en_i) begin
            count_d = count_q + c_one;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/csr_rmw_unit.sv
`default_nettype none
// ============================================================================
// Module      : csr_rmw_unit
// Description : Executes Zicsr read-modify-write instructions against the
//               machine counter file (mcycle, minstret, mcountinhibit,
//               mscratch) and the user read-only shadows (cycle/time/instret).
//               Request/response valid-ready handshakes; IDLE->EXEC->RESP.
// Revision    : 1.0 - initial release
// Ports       : clk, reset (async, active-high)
//               req_*   - request channel (funct3, address, rs1 data/field)
//               instret_inc - one instruction retired this cycle
//               resp_*  - response channel (old CSR value, illegal flag)
// ============================================================================
module csr_rmw_unit
    import csr_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int TIME_DIV = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_funct3,
    input  logic [11:0]     req_csr_addr,
    input  logic [XLEN-1:0] req_rs1_data,
    input  logic [4:0]      req_rs1_field,
    input  logic            instret_inc,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_illegal
);

    localparam logic [XLEN-1:0] c_mci_mask = (XLEN'(1) << c_mci_cy) | (XLEN'(1) << c_mci_ir);
    localparam logic [7:0]      c_presc_max = 8'(TIME_DIV - 1);

    csr_state_e state_q, state_d;

    logic [2:0]        funct3_q;
    logic [11:0]       addr_q;
    logic [XLEN-1:0]   rs1_data_q;
    logic [4:0]        rs1_field_q;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              illegal_q, illegal_d;
    logic [XLEN-1:0]   mcountinhibit_q;
    logic [XLEN-1:0]   mscratch_q;
    logic [7:0]        presc_q;

    logic [2*XLEN-1:0] mcycle_w, minstret_w, time_w;
    logic [XLEN-1:0]   old_w, operand_w, new_w;
    logic              mapped_w, wants_write_w, illegal_w, do_write_w, time_tick_w;

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    assign time_tick_w = (presc_q == c_presc_max);

    csr_counter64 #(.XLEN(XLEN)) u_mcycle (
        .clk     (clk),
        .reset   (reset),
        .en_i    (~mcountinhibit_q[c_mci_cy]),
        .wr_lo_i (do_write_w && (addr_q == c_csr_mcycle)),
        .wr_hi_i (do_write_w && (addr_q == c_csr_mcycleh)),
        .wdata_i (new_w),
        .count_o (mcycle_w)
    );

    csr_counter64 #(.XLEN(XLEN)) u_minstret (
        .clk     (clk),
        .reset   (reset),
        .en_i    (instret_inc && ~mcountinhibit_q[c_mci_ir]),
        .wr_lo_i (do_write_w && (addr_q == c_csr_minstret)),
        .wr_hi_i (do_write_w && (addr_q == c_csr_minstreth)),
        .wdata_i (new_w),
        .count_o (minstret_w)
    );

    // time is read-only from the CSR side, so its write strobes are tied off
    csr_counter64 #(.XLEN(XLEN)) u_time (
        .clk     (clk),
        .reset   (reset),
        .en_i    (time_tick_w),
        .wr_lo_i (1'b0),
        .wr_hi_i (1'b0),
        .wdata_i ('0),
        .count_o (time_w)
    );

    // ------------------------------------------------------------------
    // Read mux, operand select and modify
    // ------------------------------------------------------------------
    always_comb begin
        old_w    = '0;
        mapped_w = 1'b1;
        case (addr_q)
            c_csr_cycle,   c_csr_mcycle:    old_w = mcycle_w[XLEN-1:0];
            c_csr_cycleh,  c_csr_mcycleh:   old_w = mcycle_w[2*XLEN-1:XLEN];
            c_csr_instret, c_csr_minstret:  old_w = minstret_w[XLEN-1:0];
            c_csr_instreth, c_csr_minstreth: old_w = minstret_w[2*XLEN-1:XLEN];
            c_csr_time:                     old_w = time_w[XLEN-1:0];
            c_csr_timeh:                    old_w = time_w[2*XLEN-1:XLEN];
            c_csr_mcountinhibit:            old_w = mcountinhibit_q;
            c_csr_mscratch:                 old_w = mscratch_q;
            default:                        mapped_w = 1'b0;
        endcase
    end

    assign operand_w = funct3_q[2] ? {{(XLEN-5){1'b0}}, rs1_field_q} : rs1_data_q;

    always_comb begin
        new_w = old_w;
        case (funct3_q[1:0])
            2'b01:   new_w = operand_w;
            2'b10:   new_w = old_w | operand_w;
            2'b11:   new_w = old_w & ~operand_w;
            default: new_w = old_w;
        endcase
    end

    // Set/clear with x0/zimm=0 is a pure read and may target read-only CSRs
    assign wants_write_w = (funct3_q[1:0] == 2'b01) || (rs1_field_q != 5'd0);
    assign illegal_w     = !mapped_w
                        || (funct3_q[1:0] == 2'b00)
                        || (wants_write_w && (addr_q[11:10] == 2'b11));
    assign do_write_w    = (state_q == ST_EXEC) && wants_write_w && !illegal_w;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        rdata_d    = rdata_q;
        illegal_d  = illegal_q;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                rdata_d   = old_w;
                illegal_d = illegal_w;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            funct3_q        <= '0;
            addr_q          <= '0;
            rs1_data_q      <= '0;
            rs1_field_q     <= '0;
            rdata_q         <= '0;
            illegal_q       <= 1'b0;
            mcountinhibit_q <= '0;
            mscratch_q      <= '0;
            presc_q         <= '0;
        end else begin
            if (state_q == ST_IDLE && req_valid) begin
                funct3_q    <= req_funct3;
                addr_q      <= req_csr_addr;
                rs1_data_q  <= req_rs1_data;
                rs1_field_q <= req_rs1_field;
            end
            rdata_q   <= rdata_d;
            illegal_q <= illegal_d;
            if (do_write_w && addr_q == c_csr_mcountinhibit)
                mcountinhibit_q <= new_w & c_mci_mask;
            if (do_write_w && addr_q == c_csr_mscratch)
                mscratch_q <= new_w;
            presc_q <= time_tick_w ? 8'd0 : presc_q + 8'd1;
        end
    end

    assign resp_rdata   = rdata_q;
    assign resp_illegal = illegal_q;

endmodule
`default_nettype wire
